// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: ALU class codes and opcode constants shared by the controller and its datapath
package multicycle_ctrl_pkg;
    typedef logic [1:0] aluop_t;
    localparam aluop_t ALU_LOAD   = 2'b00;
    localparam aluop_t ALU_STORE  = 2'b01;
    localparam aluop_t ALU_BRANCH = 2'b10;
    localparam aluop_t ALU_R      = 2'b11;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath/memory signal bundle; master is the controller
interface multicycle_ctrl_if;
    logic                         run;
    logic [6:0]                   opcode;
    logic                         mem_ready;
    logic                         mem_read;
    logic                         mem_write;
    logic                         ir_write;
    logic                         pc_write;
    logic                         pc_write_cond;
    logic                         reg_write;
    logic                         mem_to_reg;
    logic                         alusrc_a;
    logic                         alusrc_b;
    multicycle_ctrl_pkg::aluop_t  aluop;
    logic                         instr_done;
    logic                         illegal_instr;
    logic [3:0]                   state;
    modport master (
        input  run, opcode, mem_ready,
        output mem_read, mem_write, ir_write, pc_write, pc_write_cond, reg_write,
               mem_to_reg, alusrc_a, alusrc_b, aluop, instr_done, illegal_instr, state
    );
    modport slave (
        output run, opcode, mem_ready,
        input  mem_read, mem_write, ir_write, pc_write, pc_write_cond, reg_write,
               mem_to_reg, alusrc_a, alusrc_b, aluop, instr_done, illegal_instr, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle CPU control FSM; CTRL_PERF_CNT_EN adds cycle/instret counters
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter bit RESET_PC_HOLD = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instret_cnt
`endif
);
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR,
        MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, TRAP
    } state_t;

    state_t cur, nxt;
    logic   run_q, go, done, next_instr;
    state_t after;

    assign go    = RESET_PC_HOLD ? bus.run & ~run_q : bus.run;
    assign after = bus.run ? FETCH : IDLE;

    // next-state selection; run only gates the return to FETCH, never aborts an instruction
    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:     nxt = go ? FETCH : IDLE;
            FETCH:    nxt = bus.mem_ready ? DECODE : FETCH;
            DECODE:   nxt = (bus.opcode == OP_R) ? EXEC_R :
                            (bus.opcode == OP_I) ? EXEC_I :
                            (bus.opcode == OP_LOAD || bus.opcode == OP_STORE) ? MEM_ADDR :
                            (bus.opcode == OP_BRANCH) ? BRANCH : TRAP;
            EXEC_R,
            EXEC_I:   nxt = WB_ALU;
            MEM_ADDR: nxt = (bus.opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            MEM_RD:   nxt = bus.mem_ready ? WB_MEM : MEM_RD;
            MEM_WR:   nxt = bus.mem_ready ? after : MEM_WR;
            WB_ALU,
            WB_MEM,
            BRANCH,
            TRAP:     nxt = after;
            default:  nxt = IDLE;
        endcase
    end

    // state register; async reset parks in IDLE so every strobe drops at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur   <= IDLE;
            run_q <= 1'b0;
        end else begin
            cur   <= nxt;
            run_q <= bus.run;
        end
    end

    assign done       = cur == WB_ALU || cur == WB_MEM || cur == BRANCH || (cur == MEM_WR && bus.mem_ready);
    assign next_instr = cur == FETCH && bus.mem_ready;

    assign bus.state         = cur;
    assign bus.mem_read      = cur == FETCH || cur == MEM_RD;
    assign bus.mem_write     = cur == MEM_WR;
    assign bus.ir_write      = next_instr;
    assign bus.pc_write      = next_instr;
    assign bus.pc_write_cond = cur == BRANCH;
    assign bus.reg_write     = cur == WB_ALU || cur == WB_MEM;
    assign bus.mem_to_reg    = cur == WB_MEM;
    assign bus.alusrc_a      = cur == EXEC_R || cur == EXEC_I || cur == MEM_ADDR || cur == BRANCH;
    assign bus.alusrc_b      = cur == EXEC_I || cur == MEM_ADDR;
    assign bus.aluop         = (cur == EXEC_R || cur == EXEC_I) ? ALU_R :
                               (cur == MEM_ADDR) ? ((bus.opcode == OP_STORE) ? ALU_STORE : ALU_LOAD) :
                               (cur == BRANCH) ? ALU_BRANCH : ALU_LOAD;
    assign bus.instr_done    = done;
    assign bus.illegal_instr = cur == TRAP;

`ifdef CTRL_PERF_CNT_EN
    // busy-cycle and retired-instruction counters, free-running with natural wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (cur != IDLE) cycle_cnt <= cycle_cnt + 32'd1;
            if (done) instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3,
                           S_EXEC_I = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6, S_MEM_WR = 4'd7,
                           S_WB_ALU = 4'd8, S_WB_MEM = 4'd9, S_BRANCH = 4'd10, S_TRAP = 4'd11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    multicycle_ctrl_if bus();
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    multicycle_ctrl dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef CTRL_PERF_CNT_EN
        ,
        .cycle_cnt(cycle_cnt),
        .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.run = 1'b0; bus.opcode = 7'd0; bus.mem_ready = 1'b0;
        #1;
        checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", bus.state, S_IDLE); end
        checks++; if ({bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write, bus.pc_write_cond, bus.reg_write, bus.instr_done, bus.illegal_instr} !== 8'h00)
            begin errors++; $display("FAIL reset_strobes got=%b exp=00000000", {bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write, bus.pc_write_cond, bus.reg_write, bus.instr_done, bus.illegal_instr}); end
        checks++; if (bus.aluop !== ALU_LOAD) begin errors++; $display("FAIL reset_aluop got=%b exp=%b", bus.aluop, ALU_LOAD); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL idle_hold got=%0d exp=%0d", bus.state, S_IDLE); end
    endtask

    task automatic test_rtype();
        do_reset();
        bus.opcode = OP_R; bus.mem_ready = 1'b0; bus.run = 1'b1;
        checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL r_first_idle got=%0d exp=%0d", bus.state, S_IDLE); end
        step();
        checks++; if (bus.state !== S_FETCH || bus.mem_read !== 1'b1 || bus.ir_write !== 1'b0)
            begin errors++; $display("FAIL r_fetch_wait state=%0d rd=%b irw=%b exp=1/1/0", bus.state, bus.mem_read, bus.ir_write); end
        step();
        checks++; if (bus.state !== S_FETCH) begin errors++; $display("FAIL r_fetch_hold got=%0d exp=%0d", bus.state, S_FETCH); end
        bus.mem_ready = 1'b1;
        #1;
        checks++; if (bus.ir_write !== 1'b1 || bus.pc_write !== 1'b1)
            begin errors++; $display("FAIL r_fetch_accept irw=%b pcw=%b exp=1/1", bus.ir_write, bus.pc_write); end
        step();
        checks++; if (bus.state !== S_DECODE || bus.mem_read !== 1'b0 || bus.reg_write !== 1'b0 || bus.ir_write !== 1'b0)
            begin errors++; $display("FAIL r_decode state=%0d rd=%b rw=%b irw=%b exp=2/0/0/0", bus.state, bus.mem_read, bus.reg_write, bus.ir_write); end
        step();
        checks++; if (bus.state !== S_EXEC_R || bus.aluop !== ALU_R || bus.alusrc_a !== 1'b1 || bus.alusrc_b !== 1'b0)
            begin errors++; $display("FAIL r_exec state=%0d aluop=%b a=%b b=%b exp=3/11/1/0", bus.state, bus.aluop, bus.alusrc_a, bus.alusrc_b); end
        step();
        checks++; if (bus.state !== S_WB_ALU || bus.reg_write !== 1'b1 || bus.mem_to_reg !== 1'b0 || bus.instr_done !== 1'b1 || bus.aluop !== ALU_LOAD)
            begin errors++; $display("FAIL r_wb state=%0d rw=%b m2r=%b done=%b aluop=%b exp=8/1/0/1/00", bus.state, bus.reg_write, bus.mem_to_reg, bus.instr_done, bus.aluop); end
        step();
        checks++; if (bus.state !== S_FETCH || bus.instr_done !== 1'b0) begin errors++; $display("FAIL r_next state=%0d done=%b exp=1/0", bus.state, bus.instr_done); end
    endtask

    task automatic test_itype();
        do_reset();
        bus.opcode = OP_I; bus.mem_ready = 1'b1; bus.run = 1'b1;
        step(); step(); step();
        checks++; if (bus.state !== S_EXEC_I || bus.aluop !== ALU_R || bus.alusrc_a !== 1'b1 || bus.alusrc_b !== 1'b1)
            begin errors++; $display("FAIL i_exec state=%0d aluop=%b a=%b b=%b exp=4/11/1/1", bus.state, bus.aluop, bus.alusrc_a, bus.alusrc_b); end
        step();
        checks++; if (bus.state !== S_WB_ALU || bus.instr_done !== 1'b1) begin errors++; $display("FAIL i_wb state=%0d done=%b exp=8/1", bus.state, bus.instr_done); end
    endtask

    task automatic test_load_wait();
        do_reset();
        bus.opcode = OP_LOAD; bus.mem_ready = 1'b1; bus.run = 1'b1;
        step(); step(); step();
        checks++; if (bus.state !== S_MEM_ADDR || bus.aluop !== ALU_LOAD || bus.alusrc_a !== 1'b1 || bus.alusrc_b !== 1'b1)
            begin errors++; $display("FAIL ld_addr state=%0d aluop=%b a=%b b=%b exp=5/00/1/1", bus.state, bus.aluop, bus.alusrc_a, bus.alusrc_b); end
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 2) bus.mem_ready = 1'b1;
            checks++; if (bus.state !== S_MEM_RD || bus.mem_read !== 1'b1 || bus.instr_done !== 1'b0)
                begin errors++; $display("FAIL ld_rd%0d state=%0d rd=%b done=%b exp=6/1/0", i, bus.state, bus.mem_read, bus.instr_done); end
        end
        step();
        checks++; if (bus.state !== S_WB_MEM || bus.mem_read !== 1'b0 || bus.reg_write !== 1'b1 || bus.mem_to_reg !== 1'b1 || bus.instr_done !== 1'b1)
            begin errors++; $display("FAIL ld_wb state=%0d rd=%b rw=%b m2r=%b done=%b exp=9/0/1/1/1", bus.state, bus.mem_read, bus.reg_write, bus.mem_to_reg, bus.instr_done); end
    endtask

    task automatic test_store();
        do_reset();
        bus.opcode = OP_STORE; bus.mem_ready = 1'b1; bus.run = 1'b1;
        step(); step(); step();
        checks++; if (bus.state !== S_MEM_ADDR || bus.aluop !== ALU_STORE) begin errors++; $display("FAIL st_addr state=%0d aluop=%b exp=5/01", bus.state, bus.aluop); end
        step();
        checks++; if (bus.state !== S_MEM_WR || bus.mem_write !== 1'b1 || bus.instr_done !== 1'b1 || bus.reg_write !== 1'b0)
            begin errors++; $display("FAIL st_wr state=%0d wr=%b done=%b rw=%b exp=7/1/1/0", bus.state, bus.mem_write, bus.instr_done, bus.reg_write); end
        step();
        checks++; if (bus.state !== S_FETCH || bus.mem_write !== 1'b0) begin errors++; $display("FAIL st_next state=%0d wr=%b exp=1/0", bus.state, bus.mem_write); end
    endtask

    task automatic test_illegal();
        do_reset();
        bus.opcode = 7'b1111111; bus.mem_ready = 1'b1; bus.run = 1'b1;
        step(); step(); step();
        checks++; if (bus.state !== S_TRAP || bus.illegal_instr !== 1'b1 || bus.instr_done !== 1'b0 || bus.reg_write !== 1'b0 || bus.mem_write !== 1'b0 || bus.pc_write !== 1'b0)
            begin errors++; $display("FAIL trap state=%0d ill=%b done=%b rw=%b wr=%b pcw=%b exp=11/1/0/0/0/0", bus.state, bus.illegal_instr, bus.instr_done, bus.reg_write, bus.mem_write, bus.pc_write); end
        step();
        checks++; if (bus.state !== S_FETCH || bus.illegal_instr !== 1'b0) begin errors++; $display("FAIL trap_next state=%0d ill=%b exp=1/0", bus.state, bus.illegal_instr); end
    endtask

    task automatic test_branch_stop();
        do_reset();
        bus.opcode = OP_BRANCH; bus.mem_ready = 1'b1; bus.run = 1'b1;
        step(); step();
        bus.run = 1'b0;
        step();
        checks++; if (bus.state !== S_BRANCH || bus.pc_write_cond !== 1'b1 || bus.aluop !== ALU_BRANCH || bus.alusrc_a !== 1'b1 || bus.alusrc_b !== 1'b0 || bus.instr_done !== 1'b1)
            begin errors++; $display("FAIL br state=%0d pwc=%b aluop=%b a=%b b=%b done=%b exp=10/1/10/1/0/1", bus.state, bus.pc_write_cond, bus.aluop, bus.alusrc_a, bus.alusrc_b, bus.instr_done); end
        step();
        checks++; if (bus.state !== S_IDLE || bus.pc_write_cond !== 1'b0) begin errors++; $display("FAIL br_idle state=%0d pwc=%b exp=0/0", bus.state, bus.pc_write_cond); end
        step(); step();
        checks++; if (bus.state !== S_IDLE || bus.mem_read !== 1'b0) begin errors++; $display("FAIL br_park state=%0d rd=%b exp=0/0", bus.state, bus.mem_read); end
    endtask

    task automatic test_reset_store();
        do_reset();
        bus.opcode = OP_STORE; bus.mem_ready = 1'b1; bus.run = 1'b1;
        step(); step(); step();
        bus.mem_ready = 1'b0;
        step();
        checks++; if (bus.state !== S_MEM_WR || bus.mem_write !== 1'b1) begin errors++; $display("FAIL rs_wr state=%0d wr=%b exp=7/1", bus.state, bus.mem_write); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.state !== S_IDLE || bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0 || bus.aluop !== ALU_LOAD)
            begin errors++; $display("FAIL rs_async state=%0d wr=%b rd=%b aluop=%b exp=0/0/0/00", bus.state, bus.mem_write, bus.mem_read, bus.aluop); end
        step();
        rst_n = 1'b1;
        bus.run = 1'b0;
    endtask

`ifdef CTRL_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        bus.opcode = OP_R; bus.mem_ready = 1'b1; bus.run = 1'b1;
        checks++; if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin errors++; $display("FAIL perf_reset cyc=%0d ret=%0d exp=0/0", cycle_cnt, instret_cnt); end
        for (int i = 0; i < 40; i++) step();
        bus.run = 1'b0;
        step();
        checks++; if (bus.state !== S_IDLE || cycle_cnt !== 32'd40 || instret_cnt !== 32'd10)
            begin errors++; $display("FAIL perf_count state=%0d cyc=%0d ret=%0d exp=0/40/10", bus.state, cycle_cnt, instret_cnt); end
        step(); step();
        checks++; if (cycle_cnt !== 32'd40 || instret_cnt !== 32'd10) begin errors++; $display("FAIL perf_idle cyc=%0d ret=%0d exp=40/10", cycle_cnt, instret_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_load_wait();
        test_store();
        test_illegal();
        test_branch_stop();
        test_reset_store();
`ifdef CTRL_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC_HOLD, default 0, meaning: when 1, IDLE is left only on a rising edge of run.
REQ-002 The block SHALL have clk  input  1  the single system clock.
REQ-003 The block SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have run  input  1  enables sequencing; when low, the controller parks in IDLE after the current instruction.
REQ-005 The block SHALL have opcode  input  7  instruction register bits [6:0].
REQ-006 The block SHALL have mem_ready  input  1  memory handshake: the access completes in a cycle where the request and mem_ready are both high.
REQ-007 The block SHALL have the following level outputs, each 1 bit: mem_read, mem_write, ir_write, pc_write, pc_write_cond, reg_write, mem_to_reg, alusrc_a (0=PC, 1=rs1), alusrc_b (0=rs2, 1=imm).
REQ-008 The block SHALL have aluop  output  2  ALU class code driven to the ALU decoder; values are `aluR, `aluLoad, `aluStore or `aluBranch.
REQ-009 The block SHALL have the following 1-cycle pulse outputs: instr_done and illegal_instr.
REQ-010 The block SHALL have state  output  4  current FSM state, for debug.

Function
REQ-011 The FSM states SHALL be IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH and TRAP. All outputs SHALL be Moore outputs decoded from the state.
REQ-012 IDLE SHALL go to FETCH when run=1. With RESET_PC_HOLD=1, it SHALL instead go to FETCH only on a 0-to-1 transition of run.
REQ-013 FETCH SHALL assert mem_read. It SHALL hold while mem_ready=0. When mem_ready=1 it SHALL assert ir_write and pc_write for that cycle and go to DECODE.
REQ-014 DECODE SHALL take 1 cycle with all strobes low. It SHALL branch on opcode as follows:
- 0110011 goes to EXEC_R.
- 0010011 goes to EXEC_I.
- 0000011 or 0100011 goes to MEM_ADDR.
- 1100011 goes to BRANCH.
- Any other value goes to TRAP.
REQ-015 EXEC_R SHALL drive aluop=`aluR, alusrc_a=1 and alusrc_b=0, then go to WB_ALU. EXEC_I SHALL drive aluop=`aluR, alusrc_a=1 and alusrc_b=1, then go to WB_ALU.
REQ-016 MEM_ADDR SHALL drive alusrc_a=1 and alusrc_b=1. It SHALL drive aluop=`aluLoad for opcode 0000011 (then go to MEM_RD) and aluop=`aluStore for opcode 0100011 (then go to MEM_WR).
REQ-017 MEM_RD SHALL assert mem_read and wait for mem_ready, then go to WB_MEM. MEM_WR SHALL assert mem_write and wait for mem_ready, then pulse instr_done.
REQ-018 WB_ALU SHALL assert reg_write with mem_to_reg=0. WB_MEM SHALL assert reg_write with mem_to_reg=1. Each SHALL pulse instr_done.
REQ-019 BRANCH SHALL drive aluop=`aluBranch, alusrc_a=1, alusrc_b=0 and pc_write_cond=1 for 1 cycle, and SHALL pulse instr_done.
REQ-020 TRAP SHALL pulse illegal_instr for 1 cycle. It SHALL not pulse instr_done and SHALL have no write strobes.
REQ-021 The state after instr_done or TRAP SHALL be FETCH if run=1, otherwise IDLE.
REQ-022 Deasserting run mid-instruction SHALL NOT abort the instruction.
REQ-023 Latency from FETCH acceptance to instr_done, with zero wait-states, SHALL be:
- R-type and I-ALU: 3 cycles.
- Load: 4 cycles.
- Store: 3 cycles.
- Branch: 2 cycles.
REQ-024 opcode SHALL be sampled only in DECODE and MEM_ADDR. It SHALL be stable from the ir_write cycle until instr_done.
REQ-025 Outside the states that drive aluop, aluop SHALL be `aluLoad, which gives a plus operation for PC increment.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, all strobes and pulses to 0, aluop=`aluLoad, and all counters to 0.
REQ-027 Reset asserted during MEM_RD or MEM_WR SHALL drop mem_read and mem_write asynchronously, with no further access.
REQ-028 The first FETCH after reset SHALL occur 2 cycles after rst_n rises with run=1: the first cycle is in IDLE.

Configuration
REQ-029 With CTRL_PERF_CNT_EN defined, the block SHALL add two 32-bit outputs:
- cycle_cnt, which increments every cycle outside IDLE.
- instret_cnt, which increments on every instr_done.
Both SHALL wrap from 0xFFFFFFFF to 0.
REQ-030 Without CTRL_PERF_CNT_EN, those ports and their registers SHALL be absent, and the behaviour SHALL be otherwise identical.

Structure
REQ-031 The aluop codes and the opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH) SHALL reside in the shared define.v header. The state encoding SHALL be local to the module.
REQ-032 The block SHALL be a single module with no sub-module; the optional counters SHALL sit in a guarded block inside it.

Verification
REQ-033 The bench SHALL cover an R-type instruction: opcode=0110011, mem_ready=1 → states FETCH, DECODE, EXEC_R, WB_ALU; aluop=`aluR in EXEC_R; reg_write=1 and instr_done=1 in cycle 4.
REQ-034 The bench SHALL cover a load with wait states: opcode=0000011, mem_ready low for 2 cycles in MEM_RD → mem_read held 3 cycles, then WB_MEM with mem_to_reg=1 and instr_done=1.
REQ-035 The bench SHALL cover an illegal opcode: opcode=1111111 → TRAP, illegal_instr pulse of 1 cycle, no reg_write, next state FETCH.
REQ-036 The bench SHALL cover a branch followed by run=0: opcode=1100011 → pc_write_cond=1 with aluop=`aluBranch; run=0 → IDLE after instr_done, and the FSM stays in IDLE.
REQ-037 The bench SHALL cover reset mid-store: rst_n=0 during MEM_WR → mem_write=0 within the same cycle, state=IDLE.
REQ-038 The bench SHALL cover the performance counters (CTRL_PERF_CNT_EN): 10 back-to-back R-type instructions with zero wait-states → instret_cnt=10 and cycle_cnt=40.
